// File: rtl/gelato_simt_stack_pkg.sv
// ============================================================================
// gelato_simt_stack_pkg : shared types and helpers for the SIMT reconvergence stack
// Revision: 1.0
// ============================================================================
`default_nettype none

package gelato_simt_stack_pkg;

  typedef enum logic [1:0] {
    UPD_SEQ    = 2'd0,
    UPD_BRANCH = 2'd1,
    UPD_EXIT   = 2'd2
  } upd_kind_e;

  localparam logic [1:0] UPD_RSVD = 2'd3;

  // Index width that stays legal (>=1) for single-element ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gelato_simt_stack_if.sv
// ============================================================================
// gelato_simt_stack_if : decode-update and fetch-select bus of the SIMT stack
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gelato_simt_stack_if
  import gelato_simt_stack_pkg::*;
#(
  parameter int WARP_NUM   = 4,
  parameter int THREAD_NUM = 32,
  parameter int PC_WIDTH   = 32,
  parameter int WARP_W     = idx_width(WARP_NUM)
) ();

  logic                           upd_valid;
  logic [WARP_W-1:0]              upd_warp;
  logic [1:0]                     upd_kind;
  logic [PC_WIDTH-1:0]            upd_next_pc;
  logic [PC_WIDTH-1:0]            upd_taken_pc;
  logic [THREAD_NUM-1:0]          upd_taken_mask;
  logic [PC_WIDTH-1:0]            upd_reconv_pc;
  logic [THREAD_NUM-1:0]          upd_mask;
  logic [WARP_NUM-1:0]            fetch_grant;
  logic [WARP_NUM-1:0]            sel_valid;
  logic [WARP_NUM*PC_WIDTH-1:0]   sel_pc;
  logic [WARP_NUM*THREAD_NUM-1:0] sel_mask;

  modport master (
    output upd_valid, upd_warp, upd_kind, upd_next_pc, upd_taken_pc,
           upd_taken_mask, upd_reconv_pc, fetch_grant,
    input  upd_mask, sel_valid, sel_pc, sel_mask
  );

  modport slave (
    input  upd_valid, upd_warp, upd_kind, upd_next_pc, upd_taken_pc,
           upd_taken_mask, upd_reconv_pc, fetch_grant,
    output upd_mask, sel_valid, sel_pc, sel_mask
  );

endinterface

`default_nettype wire

// File: rtl/gelato_simt_stack_warp.sv
// ============================================================================
// gelato_warp_simt_stack : one warp's reconvergence stack, depth and fetch lock
// Optional: GELATO_SIMT_STACK_STATS_EN exposes depth and event pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gelato_warp_simt_stack
  import gelato_simt_stack_pkg::*;
#(
  parameter int THREAD_NUM  = 32,
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  init_en,
  input  wire logic [PC_WIDTH-1:0]   init_pc,
  input  wire logic [THREAD_NUM-1:0] init_mask,
  input  wire logic                  upd_en,
  input  wire upd_kind_e             upd_kind,
  input  wire logic [PC_WIDTH-1:0]   upd_next_pc,
  input  wire logic [PC_WIDTH-1:0]   upd_taken_pc,
  input  wire logic [THREAD_NUM-1:0] upd_taken_mask,
  input  wire logic [PC_WIDTH-1:0]   upd_reconv_pc,
  input  wire logic                  grant_en,
  output logic                       sel_valid,
  output logic [PC_WIDTH-1:0]        top_pc,
  output logic [THREAD_NUM-1:0]      top_mask,
`ifdef GELATO_SIMT_STACK_STATS_EN
  output logic [DEPTH_W-1:0]         depth,
  output logic                       diverge_event,
  output logic                       reconv_event,
`endif
  output logic                       ovf_event
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   rpc;
    logic [THREAD_NUM-1:0] mask;
  } simt_entry_t;

  simt_entry_t           r_stack [STACK_DEPTH];
  logic [DEPTH_W-1:0]    r_depth;
  logic                  r_inflight;

  logic [IDX_W-1:0]      w_top_idx;
  logic [IDX_W-1:0]      w_push_idx0;
  logic [IDX_W-1:0]      w_push_idx1;
  simt_entry_t           w_top;
  logic [THREAD_NUM-1:0] w_t;
  logic [THREAD_NUM-1:0] w_n;
  logic                  w_seq;
  logic [PC_WIDTH-1:0]   w_target;
  logic                  w_set_pc;
  logic [PC_WIDTH-1:0]   w_new_pc;
  logic                  w_pop;
  logic                  w_push2;
  logic                  w_ovf;
  logic                  w_reconv;

  assign w_top_idx   = IDX_W'(r_depth - DEPTH_W'(1));
  assign w_push_idx0 = IDX_W'(r_depth);
  assign w_push_idx1 = IDX_W'(r_depth + DEPTH_W'(1));
  assign w_top       = (r_depth != '0) ? r_stack[w_top_idx] : '0;

  assign sel_valid = (r_depth != '0) && !r_inflight;
  assign top_pc    = w_top.pc;
  assign top_mask  = w_top.mask;
  assign ovf_event = w_ovf;

  always_comb begin
    w_t      = upd_taken_mask & w_top.mask;
    w_n      = w_top.mask & ~w_t;
    w_seq    = 1'b0;
    w_target = upd_next_pc;
    w_set_pc = 1'b0;
    w_new_pc = upd_next_pc;
    w_pop    = 1'b0;
    w_push2  = 1'b0;
    w_ovf    = 1'b0;
    w_reconv = 1'b0;
    if (upd_en && (r_depth != '0)) begin
      case (upd_kind)
        UPD_SEQ: w_seq = 1'b1;
        UPD_BRANCH: begin
          if (w_t == '0) begin
            w_seq = 1'b1;
          end else if (w_n == '0) begin
            w_seq    = 1'b1;
            w_target = upd_taken_pc;
          end else if (int'(r_depth) + 2 > STACK_DEPTH) begin
            w_ovf = 1'b1;
          end else begin
            // Parked top resumes at the reconvergence point once both paths pop.
            w_push2  = 1'b1;
            w_set_pc = 1'b1;
            w_new_pc = upd_reconv_pc;
          end
        end
        UPD_EXIT: w_pop = 1'b1;
        default: ;
      endcase
      if (w_seq) begin
        if ((w_target == w_top.rpc) && (r_depth > DEPTH_W'(1))) begin
          w_pop    = 1'b1;
          w_reconv = 1'b1;
        end else begin
          w_set_pc = 1'b1;
          w_new_pc = w_target;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth    <= '0;
      r_inflight <= 1'b0;
    end else if (init_en) begin
      r_depth    <= (init_mask != '0) ? DEPTH_W'(1) : '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_pop)
        r_depth <= r_depth - DEPTH_W'(1);
      else if (w_push2)
        r_depth <= r_depth + DEPTH_W'(2);
      // A grant in the same cycle as an update wins: the fetch just issued is in flight.
      if (grant_en && sel_valid)
        r_inflight <= 1'b1;
      else if (upd_en)
        r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init_en) begin
      r_stack[0] <= {init_pc, {PC_WIDTH{1'b1}}, init_mask};
    end else begin
      if (w_set_pc)
        r_stack[w_top_idx].pc <= w_new_pc;
      if (w_push2) begin
        r_stack[w_push_idx0] <= {upd_next_pc, upd_reconv_pc, w_n};
        r_stack[w_push_idx1] <= {upd_taken_pc, upd_reconv_pc, w_t};
      end
    end
  end

`ifdef GELATO_SIMT_STACK_STATS_EN
  assign depth         = r_depth;
  assign diverge_event = w_push2;
  assign reconv_event  = w_reconv;
`endif

endmodule

`default_nettype wire

// File: rtl/gelato_simt_stack.sv
// ============================================================================
// gelato_simt_stack : per-warp SIMT reconvergence stacks between decode and fetch
// Optional: GELATO_SIMT_STACK_STATS_EN adds divergence/reconvergence/depth stats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gelato_simt_stack
  import gelato_simt_stack_pkg::*;
#(
  parameter int WARP_NUM    = 4,
  parameter int THREAD_NUM  = 32,
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 32,
  localparam int WARP_W     = idx_width(WARP_NUM),
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                rdy,
  input  wire logic                init_valid,
  input  wire logic [PC_WIDTH-1:0] init_pc,
  input  wire logic [31:0]         init_workers,
  gelato_simt_stack_if.slave       bus,
`ifdef GELATO_SIMT_STACK_STATS_EN
  output logic [31:0]              stat_diverge,
  output logic [31:0]              stat_reconverge,
  output logic [DEPTH_W-1:0]       stat_max_depth,
`endif
  output logic                     overflow,
  output logic                     activate_valid,
  output logic [WARP_W-1:0]        activate_warp
);

  logic                  w_init_en;
  logic                  w_upd_en;
  logic [31:0]           w_init_q;
  logic [31:0]           w_init_r;
  logic [WARP_NUM-1:0]   w_sel_valid;
  logic [WARP_NUM-1:0]   w_ovf;
  logic [PC_WIDTH-1:0]   w_top_pc   [WARP_NUM];
  logic [THREAD_NUM-1:0] w_top_mask [WARP_NUM];

  assign w_init_en = init_valid && rdy;
  assign w_upd_en  = bus.upd_valid && rdy && (bus.upd_kind != UPD_RSVD) && !init_valid;
  assign w_init_q  = init_workers / 32'(THREAD_NUM);
  assign w_init_r  = init_workers % 32'(THREAD_NUM);

`ifdef GELATO_SIMT_STACK_STATS_EN
  logic [DEPTH_W-1:0] w_depth [WARP_NUM];
  logic [WARP_NUM-1:0] w_div;
  logic [WARP_NUM-1:0] w_rec;
  logic [DEPTH_W-1:0] w_max_depth;
`endif

  for (genvar w = 0; w < WARP_NUM; w++) begin : g_warp
    logic [THREAD_NUM-1:0] w_init_mask;

    always_comb begin
      w_init_mask = '0;
      if (32'(w) < w_init_q) begin
        w_init_mask = '1;
      end else if (32'(w) == w_init_q) begin
        for (int b = 0; b < THREAD_NUM; b++)
          w_init_mask[b] = (32'(b) < w_init_r);
      end
    end

    gelato_warp_simt_stack #(
      .THREAD_NUM  (THREAD_NUM),
      .STACK_DEPTH (STACK_DEPTH),
      .PC_WIDTH    (PC_WIDTH)
    ) u_stack (
      .clk            (clk),
      .rst            (rst),
      .init_en        (w_init_en),
      .init_pc        (init_pc),
      .init_mask      (w_init_mask),
      .upd_en         (w_upd_en && (bus.upd_warp == WARP_W'(w))),
      .upd_kind       (upd_kind_e'(bus.upd_kind)),
      .upd_next_pc    (bus.upd_next_pc),
      .upd_taken_pc   (bus.upd_taken_pc),
      .upd_taken_mask (bus.upd_taken_mask),
      .upd_reconv_pc  (bus.upd_reconv_pc),
      .grant_en       (rdy && bus.fetch_grant[w]),
      .sel_valid      (w_sel_valid[w]),
      .top_pc         (w_top_pc[w]),
      .top_mask       (w_top_mask[w]),
`ifdef GELATO_SIMT_STACK_STATS_EN
      .depth          (w_depth[w]),
      .diverge_event  (w_div[w]),
      .reconv_event   (w_rec[w]),
`endif
      .ovf_event      (w_ovf[w])
    );
  end

  assign bus.sel_valid = w_sel_valid;

  always_comb begin
    bus.sel_pc   = '0;
    bus.sel_mask = '0;
    bus.upd_mask = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      bus.sel_pc[w*PC_WIDTH +: PC_WIDTH]       = w_top_pc[w];
      bus.sel_mask[w*THREAD_NUM +: THREAD_NUM] = w_top_mask[w];
      if (bus.upd_warp == WARP_W'(w))
        bus.upd_mask = w_top_mask[w];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow       <= 1'b0;
      activate_valid <= 1'b0;
      activate_warp  <= '0;
    end else if (rdy) begin
      if (init_valid)
        overflow <= 1'b0;
      else if (|w_ovf)
        overflow <= 1'b1;
      activate_valid <= w_upd_en;
      if (w_upd_en)
        activate_warp <= bus.upd_warp;
    end
  end

`ifdef GELATO_SIMT_STACK_STATS_EN
  always_comb begin
    w_max_depth = stat_max_depth;
    for (int w = 0; w < WARP_NUM; w++)
      if (w_depth[w] > w_max_depth)
        w_max_depth = w_depth[w];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_diverge    <= '0;
      stat_reconverge <= '0;
      stat_max_depth  <= '0;
    end else if (rdy) begin
      if (init_valid) begin
        stat_diverge    <= '0;
        stat_reconverge <= '0;
        stat_max_depth  <= '0;
      end else begin
        if (|w_div) stat_diverge <= stat_diverge + 32'd1;
        if (|w_rec) stat_reconverge <= stat_reconverge + 32'd1;
        stat_max_depth <= w_max_depth;
      end
    end
  end
`endif

endmodule

`default_nettype wire
